multi_phase_traffic_controller: RTL

MULTI_PHASE_TRAFFIC_CONTROLLER -- requirements
Module: multi_phase_traffic_controller

---
 rtl/traffic_pkg.sv | 18 +
 rtl/tlc_phase_timer.sv | 24 ++
 rtl/multi_phase_traffic_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and default timing for the multi-phase traffic controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        FLASH   = 2'd3
    } tlc_state_t;

    localparam int DEF_NUM_PHASES = 4;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_GREEN_T    = 15;
    localparam int DEF_YELLOW_T   = 1;
    localparam int DEF_ALLRED_T   = 1;
    localparam int DEF_PED_T      = 4;

endpackage

// File: rtl/tlc_phase_timer.sv
// Tick-qualified state timer: restarts on state entry, flags the last tick of a duration.
module tlc_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             restart,
    input  logic [CNT_W-1:0] duration,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (tick) begin
            count <= restart ? '0 : count + 1'b1;
        end
    end

    assign done = (count == duration - 1'b1);

endmodule

// File: rtl/multi_phase_traffic_controller.sv
// Round-robin signal controller with pedestrian green extension and flashing-red night mode.
module multi_phase_traffic_controller
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int GREEN_T    = DEF_GREEN_T,
    parameter int YELLOW_T   = DEF_YELLOW_T,
    parameter int ALLRED_T   = DEF_ALLRED_T,
    parameter int PED_T      = DEF_PED_T
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          tick,
    input  logic [NUM_PHASES-1:0]         ped_req,
    input  logic                          flash_mode,
    output logic [NUM_PHASES-1:0]         green,
    output logic [NUM_PHASES-1:0]         yellow,
    output logic [NUM_PHASES-1:0]         red,
    output logic [NUM_PHASES-1:0]         walk,
    output logic [$clog2(NUM_PHASES)-1:0] phase_idx
);

    localparam int PW = $clog2(NUM_PHASES);
    localparam logic [PW-1:0]    LAST_PH   = PW'(NUM_PHASES - 1);
    localparam logic [CNT_W-1:0] DUR_G     = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0] DUR_GP    = CNT_W'(GREEN_T + PED_T);
    localparam logic [CNT_W-1:0] DUR_Y     = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] DUR_AR    = CNT_W'(ALLRED_T);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(PED_T - 1);

    generate
        if (NUM_PHASES < 2 || NUM_PHASES > 8 || GREEN_T < 1 || YELLOW_T < 1 ||
            ALLRED_T < 1 || PED_T < 1 ||
            64'(GREEN_T + PED_T) >= (64'd1 << CNT_W)) begin : g_bad_params
            $error("multi_phase_traffic_controller: illegal parameter set");
        end
    endgenerate

    tlc_state_t             state, state_next;
    logic [PW-1:0]          phase_next;
    logic [NUM_PHASES-1:0]  latch, latch_clr;
    logic                   ext, ext_next;
    logic                   walk_on, walk_on_next;
    logic                   flash_on, flash_next;
    logic                   restart, timer_done;
    logic [CNT_W-1:0]       timer, duration;

    function automatic logic [NUM_PHASES-1:0] onehot(input logic [PW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    tlc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .restart  (restart),
        .duration (duration),
        .count    (timer),
        .done     (timer_done)
    );

    always_comb begin
        case (state)
            GREEN:   duration = ext ? DUR_GP : DUR_G;
            YELLOW:  duration = DUR_Y;
            default: duration = DUR_AR;
        endcase
    end

    always_comb begin
        state_next   = state;
        phase_next   = phase_idx;
        ext_next     = ext;
        walk_on_next = walk_on;
        flash_next   = flash_on;
        latch_clr    = '0;
        if (tick) begin
            case (state)
                ALL_RED: begin
                    if (timer_done) begin
                        if (flash_mode) begin
                            state_next = FLASH;
                            flash_next = 1'b1;
                        end else begin
                            // Extension decided from the latch as it stood before this green.
                            state_next   = GREEN;
                            ext_next     = latch[phase_idx];
                            walk_on_next = latch[phase_idx];
                            latch_clr    = onehot(phase_idx);
                        end
                    end
                end
                GREEN: begin
                    if (timer == WALK_LAST) walk_on_next = 1'b0;
                    if (timer_done) begin
                        state_next   = YELLOW;
                        walk_on_next = 1'b0;
                    end
                end
                YELLOW: begin
                    if (timer_done) begin
                        state_next = ALL_RED;
                        phase_next = (phase_idx == LAST_PH) ? '0 : phase_idx + 1'b1;
                        ext_next   = 1'b0;
                    end
                end
                default: begin
                    if (!flash_mode) begin
                        state_next = ALL_RED;
                        phase_next = '0;
                        flash_next = 1'b1;
                    end else begin
                        flash_next = ~flash_on;
                    end
                end
            endcase
        end
        restart = (state_next != state);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ALL_RED;
            phase_idx <= '0;
            latch     <= '0;
            ext       <= 1'b0;
            walk_on   <= 1'b0;
            flash_on  <= 1'b1;
            green     <= '0;
            yellow    <= '0;
            red       <= '1;
            walk      <= '0;
        end else begin
            state     <= state_next;
            phase_idx <= phase_next;
            latch     <= (latch & ~latch_clr) | ped_req;
            ext       <= ext_next;
            walk_on   <= walk_on_next;
            flash_on  <= flash_next;
            green     <= (state_next == GREEN)  ? onehot(phase_next) : '0;
            yellow    <= (state_next == YELLOW) ? onehot(phase_next) : '0;
            walk      <= (state_next == GREEN && walk_on_next) ? onehot(phase_next) : '0;
            case (state_next)
                ALL_RED:       red <= '1;
                GREEN, YELLOW: red <= ~onehot(phase_next);
                default:       red <= flash_next ? '1 : '0;
            endcase
        end
    end

endmodule
